// File: rtl/elastic_pipe_chain.sv
// DEPTH-stage elastic retiming chain for WIDTH-bit beats; DEPTH cycles latency (0 = combinational).
// Back-pressure: enq_ready/deq_valid come only from stage flops; FULL stages stream 1 beat/cycle, HALF 1 per 2.
module elastic_pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int MODE  = 0,
    parameter int CNT_W = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [CNT_W-1:0] count
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;

        assign deq_valid = enq_valid & ~flush;
        assign deq_bits  = enq_bits;
        assign enq_ready = deq_ready & ~flush;
        assign count     = '0;
    end else begin : g_chain
        // lnk_* index i is the input side of stage i; index DEPTH is the chain output.
        logic             lnk_vld [DEPTH+1];
        logic             lnk_rdy [DEPTH+1];
        logic [WIDTH-1:0] lnk_dat [DEPTH+1];
        logic             kill;
        logic             enq_fire;
        logic             deq_fire;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;

        assign kill         = reset | flush;
        assign lnk_vld[0]   = enq_valid & ~kill;
        assign lnk_dat[0]   = enq_bits;
        assign lnk_rdy[DEPTH] = deq_ready & ~kill;
        assign enq_ready    = lnk_rdy[0] & ~kill;
        assign deq_valid    = lnk_vld[DEPTH] & ~kill;
        assign deq_bits     = lnk_dat[DEPTH];
        assign enq_fire     = enq_valid & enq_ready;
        assign deq_fire     = deq_valid & deq_ready;
        assign count        = count_q;

        always_comb begin
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
            if (flush) begin
                count_d = '0;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (MODE == 1) begin : g_half
                logic             vld_q;
                logic             vld_d;
                logic [WIDTH-1:0] dat_q;
                logic [WIDTH-1:0] dat_d;

                assign lnk_rdy[i]   = ~vld_q;
                assign lnk_vld[i+1] = vld_q;
                assign lnk_dat[i+1] = dat_q;

                // Accept only when empty, so a beat never enters and leaves in the same cycle.
                always_comb begin
                    vld_d = vld_q;
                    dat_d = dat_q;
                    if (vld_q && lnk_rdy[i+1]) begin
                        vld_d = 1'b0;
                    end else if (lnk_vld[i] && !vld_q) begin
                        vld_d = 1'b1;
                        dat_d = lnk_dat[i];
                    end
                    if (flush) begin
                        vld_d = 1'b0;
                    end
                end

                always_ff @(posedge clock) begin
                    if (reset) begin
                        vld_q <= 1'b0;
                    end else begin
                        vld_q <= vld_d;
                    end
                    dat_q <= dat_d;
                end
            end else begin : g_full
                logic             m_vld_q;
                logic             m_vld_d;
                logic             s_vld_q;
                logic             s_vld_d;
                logic [WIDTH-1:0] m_dat_q;
                logic [WIDTH-1:0] m_dat_d;
                logic [WIDTH-1:0] s_dat_q;
                logic [WIDTH-1:0] s_dat_d;
                logic             in_fire;
                logic             m_free;

                assign lnk_rdy[i]   = ~s_vld_q;
                assign lnk_vld[i+1] = m_vld_q;
                assign lnk_dat[i+1] = m_dat_q;

                // The skid entry only fills while main is stalled, and refills main first on drain.
                always_comb begin
                    in_fire = lnk_vld[i] & ~s_vld_q;
                    m_free  = ~m_vld_q | lnk_rdy[i+1];
                    m_vld_d = m_vld_q;
                    m_dat_d = m_dat_q;
                    s_vld_d = s_vld_q;
                    s_dat_d = s_dat_q;
                    if (m_free) begin
                        if (s_vld_q) begin
                            m_vld_d = 1'b1;
                            m_dat_d = s_dat_q;
                            s_vld_d = 1'b0;
                        end else begin
                            m_vld_d = in_fire;
                            if (in_fire) begin
                                m_dat_d = lnk_dat[i];
                            end
                        end
                    end else if (in_fire) begin
                        s_vld_d = 1'b1;
                        s_dat_d = lnk_dat[i];
                    end
                    if (flush) begin
                        m_vld_d = 1'b0;
                        s_vld_d = 1'b0;
                    end
                end

                always_ff @(posedge clock) begin
                    if (reset) begin
                        m_vld_q <= 1'b0;
                        s_vld_q <= 1'b0;
                    end else begin
                        m_vld_q <= m_vld_d;
                        s_vld_q <= s_vld_d;
                    end
                    m_dat_q <= m_dat_d;
                    s_dat_q <= s_dat_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Bench for elastic_pipe_chain: four instances (FULL D3, FULL D2, HALF D2, D0) against a per-stage queue model.
module tb_elastic_pipe_chain;

    logic        clk;
    logic        rst;
    logic        ev  [4];
    logic        er  [4];
    logic        dv  [4];
    logic        dr  [4];
    logic        fl  [4];
    logic [15:0] eb  [4];
    logic [15:0] db  [4];
    logic [2:0]  cnt_f3, cnt_f2, cnt_h2;
    logic        cnt_p0;
    logic [31:0] cnt [4];

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    int dep [4] = '{3, 2, 2, 0};
    bit hlf [4] = '{0, 0, 1, 0};

    logic [15:0] mq [12][$];

    assign cnt[0] = 32'(cnt_f3);
    assign cnt[1] = 32'(cnt_f2);
    assign cnt[2] = 32'(cnt_h2);
    assign cnt[3] = 32'(cnt_p0);

    elastic_pipe_chain #(.WIDTH(16), .DEPTH(3), .MODE(0)) u_f3 (
        .clock(clk), .reset(rst), .flush(fl[0]), .enq_valid(ev[0]), .enq_ready(er[0]),
        .enq_bits(eb[0]), .deq_valid(dv[0]), .deq_ready(dr[0]), .deq_bits(db[0]), .count(cnt_f3));
    elastic_pipe_chain #(.WIDTH(16), .DEPTH(2), .MODE(0)) u_f2 (
        .clock(clk), .reset(rst), .flush(fl[1]), .enq_valid(ev[1]), .enq_ready(er[1]),
        .enq_bits(eb[1]), .deq_valid(dv[1]), .deq_ready(dr[1]), .deq_bits(db[1]), .count(cnt_f2));
    elastic_pipe_chain #(.WIDTH(16), .DEPTH(2), .MODE(1)) u_h2 (
        .clock(clk), .reset(rst), .flush(fl[2]), .enq_valid(ev[2]), .enq_ready(er[2]),
        .enq_bits(eb[2]), .deq_valid(dv[2]), .deq_ready(dr[2]), .deq_bits(db[2]), .count(cnt_h2));
    elastic_pipe_chain #(.WIDTH(16), .DEPTH(0), .MODE(0)) u_p0 (
        .clock(clk), .reset(rst), .flush(fl[3]), .enq_valid(ev[3]), .enq_ready(er[3]),
        .enq_bits(eb[3]), .deq_valid(dv[3]), .deq_ready(dr[3]), .deq_bits(db[3]), .count(cnt_p0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Model: each stage is a small FIFO (2 slots FULL, 1 slot HALF); readiness seen
    // upstream depends only on the stage's occupancy at the start of the cycle.
    int          md;
    bit          kill;
    bit          rin [4];
    bit          mv  [3];
    bit          e_er, e_dv;
    logic [15:0] e_db, x;
    int          e_cnt;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 4; d++) begin
                md = dep[d];
                kill = rst | fl[d];
                e_db = '0;
                e_cnt = 0;
                if (md == 0) begin
                    e_er = dr[d] & ~fl[d];
                    e_dv = ev[d] & ~fl[d];
                    e_db = eb[d];
                end else begin
                    for (int s = 0; s < md; s++) begin
                        rin[s] = hlf[d] ? (mq[d*3+s].size() == 0) : (mq[d*3+s].size() < 2);
                        e_cnt += mq[d*3+s].size();
                    end
                    rin[md] = dr[d] & ~kill;
                    e_er = rin[0] & ~kill;
                    e_dv = (mq[d*3+md-1].size() != 0) & ~kill;
                    if (e_dv) e_db = mq[d*3+md-1][0];
                end
                chk("enq_ready", d, 32'(er[d]), 32'(e_er));
                chk("deq_valid", d, 32'(dv[d]), 32'(e_dv));
                if (e_dv) chk("deq_bits", d, 32'(db[d]), 32'(e_db));
                chk("count", d, cnt[d], 32'(e_cnt));
                if (md > 0) begin
                    if (kill) begin
                        for (int s = 0; s < md; s++) mq[d*3+s].delete();
                    end else begin
                        for (int s = 0; s < md; s++) mv[s] = (mq[d*3+s].size() > 0) && rin[s+1];
                        for (int s = md - 1; s >= 0; s--) begin
                            if (mv[s]) begin
                                x = mq[d*3+s].pop_front();
                                if (s < md - 1) mq[d*3+s+1].push_back(x);
                            end
                        end
                        if (ev[d] && e_er) mq[d*3].push_back(eb[d]);
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] k, expd;
        int first_e, first_d, last_d, got, acc, nd, nf;

        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            ev[d] = (d < 3); eb[d] = 16'h00F0 + 16'(d); dr[d] = 1'b0; fl[d] = 1'b0;
        end
        @(posedge clk);
        chk_en = 1;
        #1;
        // reset held with enq_valid high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_rst_enq_ready", 0, 32'(er[0]), 0);
            chk("t1_rst_deq_valid", 0, 32'(dv[0]), 0);
            chk("t1_rst_count", 0, cnt[0], 0);
            nxt();
        end
        rst = 1'b0;
        for (int d = 0; d < 3; d++) ev[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("t1_post_enq_ready", d, 32'(er[d]), 1);
        nxt();

        // FULL D3 streaming 0x1..0x10
        dr[0] = 1'b1; k = 16'h1; got = 1; first_e = -1; first_d = -1; last_d = -1;
        for (int t = 0; t < 40; t++) begin
            ev[0] = (k <= 16'h10); eb[0] = k;
            @(negedge clk);
            if (ev[0] && er[0]) begin
                if (first_e < 0) first_e = t;
                k++;
            end
            if (dv[0]) begin
                chk("t2_data", 0, 32'(db[0]), 32'(got));
                got++; last_d = t;
                if (first_d < 0) first_d = t;
            end
            if (t >= 3 && t <= 15) chk("t2_count", 0, cnt[0], 3);
            nxt();
        end
        ev[0] = 1'b0;
        chk("t2_latency", 0, 32'(first_d - first_e), 3);
        chk("t2_beats", 0, 32'(got - 1), 16);
        chk("t2_no_bubble", 0, 32'(last_d - first_d), 15);

        // FULL D2 back-pressure
        dr[1] = 1'b0; ev[1] = 1'b1; k = 16'h21; acc = 0;
        for (int t = 0; t < 8; t++) begin
            eb[1] = k;
            @(negedge clk);
            if (er[1]) begin acc++; k++; end
            nxt();
        end
        chk("t3_accepted", 1, 32'(acc), 4);
        eb[1] = k;
        @(negedge clk);
        chk("t3_full_enq_ready", 1, 32'(er[1]), 0);
        chk("t3_full_count", 1, cnt[1], 4);
        nxt();
        dr[1] = 1'b1; expd = 16'h21; nd = 0; nf = 0;
        for (int t = 0; t < 12; t++) begin
            eb[1] = k;
            @(negedge clk);
            if (er[1]) begin k++; nf++; end
            if (dv[1]) begin
                chk("t3_order", 1, 32'(db[1]), 32'(expd));
                expd++; nd++;
            end
            nxt();
        end
        ev[1] = 1'b0;
        chk("t3_drained_ge8", 1, 32'(nd >= 8), 1);
        chk("t3_resumed_ge4", 1, 32'(nf >= 4), 1);

        // HALF D2 streaming
        dr[2] = 1'b1; ev[2] = 1'b1; k = 16'h41; expd = 16'h41;
        for (int t = 0; t < 16; t++) begin
            eb[2] = k;
            @(negedge clk);
            chk("t4_enq_every_other", 2, 32'(er[2]), 32'(t % 2 == 0));
            if (er[2]) k++;
            if (t >= 2) chk("t4_deq_every_other", 2, 32'(dv[2]), 32'(t % 2 == 0));
            if (dv[2]) begin
                chk("t4_order", 2, 32'(db[2]), 32'(expd));
                expd++;
            end
            nxt();
        end
        ev[2] = 1'b0;
        for (int t = 0; t < 4; t++) nxt();

        // flush with count=3 and enq_valid high
        dr[0] = 1'b0; ev[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            eb[0] = 16'h50 + 16'(i);
            @(negedge clk);
            chk("t5_fill_enq_ready", 0, 32'(er[0]), 1);
            nxt();
        end
        fl[0] = 1'b1; eb[0] = 16'h77;
        @(negedge clk);
        chk("t5_flush_count_before", 0, cnt[0], 3);
        chk("t5_flush_enq_ready", 0, 32'(er[0]), 0);
        chk("t5_flush_deq_valid", 0, 32'(dv[0]), 0);
        nxt();
        fl[0] = 1'b0; ev[0] = 1'b0; dr[0] = 1'b1;
        @(negedge clk);
        chk("t5_after_count", 0, cnt[0], 0);
        chk("t5_after_deq_valid", 0, 32'(dv[0]), 0);
        nxt();
        ev[0] = 1'b1; eb[0] = 16'hA5;
        @(negedge clk);
        chk("t5_a5_enq_ready", 0, 32'(er[0]), 1);
        nxt();
        ev[0] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            chk("t5_a5_deq_valid", 0, 32'(dv[0]), 32'(t == 3));
            if (t == 3) chk("t5_a5_bits", 0, 32'(db[0]), 32'h00A5);
            nxt();
        end

        // DEPTH=0 pinned literals
        ev[3] = 1'b1; dr[3] = 1'b1; eb[3] = 16'h1234; fl[3] = 1'b1;
        @(negedge clk);
        chk("t6_flush_deq_valid", 3, 32'(dv[3]), 0);
        chk("t6_flush_enq_ready", 3, 32'(er[3]), 0);
        nxt();
        fl[3] = 1'b0;
        @(negedge clk);
        chk("t6_deq_valid", 3, 32'(dv[3]), 1);
        chk("t6_enq_ready", 3, 32'(er[3]), 1);
        chk("t6_bits", 3, 32'(db[3]), 32'h1234);
        nxt();

        // randomized traffic on all instances, with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 4; d++) begin
                ev[d] = ($urandom_range(0, 3) != 0);
                eb[d] = 16'($urandom);
                dr[d] = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                fl[d] = ($urandom_range(0, 40) == 0);
            end
            rst = ($urandom_range(0, 300) == 0);
            nxt();
        end
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            ev[d] = 1'b0; fl[d] = 1'b0; dr[d] = 1'b1;
        end
        for (int t = 0; t < 10; t++) nxt();
        for (int d = 0; d < 3; d++) chk("end_drained_count", d, cnt[d], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
